// File: rtl/count_sequence_checker_pkg.sv
// Shared definitions for the counter sequence checker: FSM encoding and
// step classification used by the top-level monitor.
package count_sequence_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_GOOD  = 2'd0,
        STEP_STALL = 2'd1,
        STEP_BAD   = 2'd2
    } step_t;

    localparam int DEF_WIDTH     = 3;
    localparam int DEF_ERR_LIMIT = 3;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/count_sequence_checker_gray.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of the
// Gray bits from itself up to the MSB.
module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign o_bin[gi] = ^(i_gray >> gi);
        end
    endgenerate

endmodule

// File: rtl/count_sequence_checker.sv
// Downstream monitor for a binary/Gray up-counter: decodes each sample,
// classifies the step against the previous one and tracks lock/fault status.
module count_sequence_checker
    import count_sequence_checker_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ERR_LIMIT = DEF_ERR_LIMIT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] bin_value,
    output logic             locked,
    output logic             fault,
    output logic             step_ok,
    output logic             seq_err,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [1:0]       state_dbg
);

    localparam int BR_W = $clog2(ERR_LIMIT + 1);
    localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};

    state_t           r_state;
    logic [WIDTH-1:0] r_prev_v;
    logic             r_prev_mode;
    logic [BR_W-1:0]  r_bad_run;
    logic [WIDTH-1:0] r_bin_value;
    logic             r_step_ok;
    logic             r_seq_err;
    logic             r_wrap_pulse;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_wrap_count;

    logic [WIDTH-1:0] w_gray_bin;
    logic [WIDTH-1:0] w_v;
    logic [WIDTH-1:0] w_prev_inc;
    logic [BR_W-1:0]  w_bad_inc;
    logic             w_mode_chg;
    step_t            w_step;

    state_t           w_state_nxt;
    logic [BR_W-1:0]  w_bad_run_nxt;
    logic             w_step_ok_nxt;
    logic             w_seq_err_nxt;
    logic             w_wrap_pulse_nxt;
    logic [CNT_W-1:0] w_err_count_nxt;
    logic [CNT_W-1:0] w_wrap_count_nxt;

    gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
        .i_gray (count),
        .o_bin  (w_gray_bin)
    );

    assign w_v        = mode ? w_gray_bin : count;
    assign w_prev_inc = r_prev_v + WIDTH'(1);
    assign w_bad_inc  = r_bad_run + BR_W'(1);
    assign w_mode_chg = (mode != r_prev_mode);

    always_comb begin
        w_step = STEP_BAD;
        if (w_v == w_prev_inc) begin
            w_step = STEP_GOOD;
        end else if (w_v == r_prev_v) begin
            w_step = STEP_STALL;
        end
    end

    // Next-state and pulse decode; a mode change overrides any step check.
    always_comb begin
        w_state_nxt      = r_state;
        w_bad_run_nxt    = r_bad_run;
        w_step_ok_nxt    = 1'b0;
        w_seq_err_nxt    = 1'b0;
        w_wrap_pulse_nxt = 1'b0;
        w_err_count_nxt  = r_err_count;
        w_wrap_count_nxt = r_wrap_count;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (w_mode_chg) begin
                    w_bad_run_nxt = '0;
                end else if (w_step == STEP_GOOD) begin
                    w_state_nxt   = ST_LOCKED;
                    w_step_ok_nxt = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_mode_chg) begin
                    w_state_nxt   = ST_ACQUIRE;
                    w_bad_run_nxt = '0;
                end else if (w_step == STEP_GOOD) begin
                    w_step_ok_nxt = 1'b1;
                    w_bad_run_nxt = '0;
                end else if (w_step == STEP_BAD) begin
                    w_seq_err_nxt = 1'b1;
                    w_bad_run_nxt = w_bad_inc;
                    if (r_err_count != {CNT_W{1'b1}}) begin
                        w_err_count_nxt = r_err_count + CNT_W'(1);
                    end
                    if (w_bad_inc >= BR_W'(ERR_LIMIT)) begin
                        w_state_nxt = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_step_ok_nxt && (r_prev_v == MAX_V)) begin
            w_wrap_pulse_nxt = 1'b1;
            w_wrap_count_nxt = r_wrap_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_prev_v     <= '0;
            r_prev_mode  <= 1'b0;
            r_bad_run    <= '0;
            r_bin_value  <= '0;
            r_step_ok    <= 1'b0;
            r_seq_err    <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_err_count  <= '0;
            r_wrap_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_v     <= w_v;
            r_prev_mode  <= mode;
            r_bad_run    <= w_bad_run_nxt;
            r_bin_value  <= w_v;
            r_step_ok    <= w_step_ok_nxt;
            r_seq_err    <= w_seq_err_nxt;
            r_wrap_pulse <= w_wrap_pulse_nxt;
            r_err_count  <= w_err_count_nxt;
            r_wrap_count <= w_wrap_count_nxt;
        end
    end

    assign bin_value  = r_bin_value;
    assign locked     = (r_state == ST_LOCKED);
    assign fault      = (r_state == ST_FAULT);
    assign step_ok    = r_step_ok;
    assign seq_err    = r_seq_err;
    assign wrap_pulse = r_wrap_pulse;
    assign err_count  = r_err_count;
    assign wrap_count = r_wrap_count;
    assign state_dbg  = r_state;

endmodule
